// File: rtl/button_pkg.sv
// Shared constants and types for the floor-button detector.
// Optional feature macro: BUTTON_TOGGLE_EN (see btn_contact_fsm.sv).
package button_pkg;

  // Array dimensions shared by the top level and the bench.
  localparam int N_PLAYER   = 2;
  localparam int N_BUTTON   = 4;

  // Buttons are placed on a 16-pixel tile grid.
  localparam int TILE_SHIFT = 4;

  // Per-pair hold-timer state.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HOLD    = 2'd2
  } btn_state_t;

  // Default level layout: button tile column/row, indexed by button number.
  localparam logic [9:0] DEF_BTN_TILE_X [N_BUTTON] = '{10'd15, 10'd10, 10'd20, 10'd28};
  localparam logic [9:0] DEF_BTN_TILE_Y [N_BUTTON] = '{10'd21, 10'd16, 10'd16, 10'd12};

  // Convert a tile coordinate to an 11-bit pixel coordinate.
  function automatic logic [10:0] tile_to_px(input logic [9:0] tile);
    logic [10:0] wide;
    wide = {1'b0, tile};
    return wide << TILE_SHIFT;
  endfunction

endpackage

// File: rtl/btn_contact_fsm.sv
// One (player, button) pair: registered contact detection, hold-timer FSM
// and registered trigger output.
// Optional feature macro: BUTTON_TOGGLE_EN -- when defined, each pair keeps
// a toggle bit flipped on every IDLE->PRESSED transition and the trigger
// follows that bit instead of the hold-timer state.
module btn_contact_fsm
  import button_pkg::*;
#(
  parameter int PLAYER_W    = 16,
  parameter int PLAYER_H    = 32,
  parameter int BTN_W       = 16,
  parameter int BTN_H       = 4,
  parameter int HOLD_FRAMES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] player_x,
  input  logic [9:0] player_y,
  input  logic [9:0] button_x,
  input  logic [9:0] button_y,
  output logic       contact,
  output logic       trigger
);

  // Counter only needs to hold HOLD_FRAMES-1.
  localparam int CNT_W     = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam int HOLD_LOAD = (HOLD_FRAMES > 0) ? (HOLD_FRAMES - 1) : 0;
  localparam logic [CNT_W-1:0] CNT_LOAD = HOLD_LOAD[CNT_W-1:0];

  logic [10:0] bx_s;
  logic [10:0] by_s;
  logic [10:0] px_s;
  logic [10:0] feet_s;

  logic             contact_d;
  logic             contact_q;
  btn_state_t       state_d;
  btn_state_t       state_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;
  logic             trigger_d;
  logic             trigger_q;

  // Geometric overlap test between the player's feet and the button band.
  // Edge touching on the right side (px + width == bx) is not contact.
  always_comb begin
    bx_s      = tile_to_px(button_x);
    by_s      = tile_to_px(button_y);
    px_s      = {1'b0, player_x};
    feet_s    = {1'b0, player_y} + 11'(PLAYER_H);
    contact_d = (feet_s >= by_s) &&
                (feet_s <= (by_s + 11'(BTN_H))) &&
                (px_s < (bx_s + 11'(BTN_W))) &&
                ((px_s + 11'(PLAYER_W)) > bx_s);
  end

  // Hold-timer FSM driven by the registered contact.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (contact_q) begin
          state_d = PRESSED;
        end else begin
          state_d = IDLE;
        end
      end
      PRESSED: begin
        if (contact_q) begin
          state_d = PRESSED;
        end else if (HOLD_FRAMES == 0) begin
          state_d = IDLE;
        end else begin
          state_d = HOLD;
          cnt_d   = CNT_LOAD;
        end
      end
      HOLD: begin
        if (contact_q) begin
          // Re-contact: drop the running countdown, the next loss reloads it.
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef BUTTON_TOGGLE_EN
  logic toggle_d;
  logic toggle_q;

  // Latch-style output: flip on every fresh press from IDLE.
  always_comb begin
    if ((state_q == IDLE) && (state_d == PRESSED)) begin
      toggle_d = ~toggle_q;
    end else begin
      toggle_d = toggle_q;
    end
    trigger_d = toggle_d;
  end

  // Toggle bit register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      toggle_q <= 1'b0;
    end else begin
      toggle_q <= toggle_d;
    end
  end
`else
  // Trigger is asserted in every state except IDLE.
  always_comb begin
    if (state_d != IDLE) begin
      trigger_d = 1'b1;
    end else begin
      trigger_d = 1'b0;
    end
  end
`endif

  // State, counter, contact and trigger registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      contact_q <= 1'b0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      trigger_q <= 1'b0;
    end else begin
      contact_q <= contact_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      trigger_q <= trigger_d;
    end
  end

  assign contact = contact_q;
  assign trigger = trigger_q;

endmodule

// File: rtl/button_detect.sv
// Floor-button detector: per-(player, button) contact/hold FSMs plus a
// per-button sink-depth counter for the sprite renderer.
// Optional feature macro: BUTTON_TOGGLE_EN (latching buttons).
module button_detect
  import button_pkg::*;
#(
  parameter int PLAYER_W    = 16,
  parameter int PLAYER_H    = 32,
  parameter int BTN_W       = 16,
  parameter int BTN_H       = 4,
  parameter int HOLD_FRAMES = 8,
  parameter int PRESS_DEPTH = 3
) (
  input  logic       frame_clk,
  input  logic       RESET_n,
  input  logic [9:0] playerX       [N_PLAYER],
  input  logic [9:0] playerY       [N_PLAYER],
  input  logic [9:0] buttonX       [N_BUTTON],
  input  logic [9:0] buttonY       [N_BUTTON],
  output logic       buttonTrigger [N_PLAYER][N_BUTTON],
  output logic [1:0] buttonDepth   [N_BUTTON],
  output logic       contact       [N_PLAYER][N_BUTTON]
);

  // Depth is a 2-bit quantity; larger settings are not meaningful.
  localparam logic [1:0] DEPTH_MAX = PRESS_DEPTH[1:0];

  logic       any_trig_s [N_BUTTON];
  logic [1:0] depth_d    [N_BUTTON];
  logic [1:0] depth_q    [N_BUTTON];

  // One independent pair engine per (player, button).
  for (genvar p = 0; p < N_PLAYER; p++) begin : g_player
    for (genvar b = 0; b < N_BUTTON; b++) begin : g_button
      btn_contact_fsm #(
        .PLAYER_W    (PLAYER_W),
        .PLAYER_H    (PLAYER_H),
        .BTN_W       (BTN_W),
        .BTN_H       (BTN_H),
        .HOLD_FRAMES (HOLD_FRAMES)
      ) u_pair (
        .clk      (frame_clk),
        .rst_n    (RESET_n),
        .player_x (playerX[p]),
        .player_y (playerY[p]),
        .button_x (buttonX[b]),
        .button_y (buttonY[b]),
        .contact  (contact[p][b]),
        .trigger  (buttonTrigger[p][b])
      );
    end
  end

  // Depth ramps toward PRESS_DEPTH while any player triggers the button,
  // and back toward zero otherwise, one pixel per frame.
  always_comb begin
    for (int b = 0; b < N_BUTTON; b++) begin
      any_trig_s[b] = 1'b0;
      for (int p = 0; p < N_PLAYER; p++) begin
        any_trig_s[b] = any_trig_s[b] | buttonTrigger[p][b];
      end
      if (any_trig_s[b]) begin
        if (depth_q[b] < DEPTH_MAX) begin
          depth_d[b] = depth_q[b] + 2'd1;
        end else begin
          depth_d[b] = DEPTH_MAX;
        end
      end else begin
        if (depth_q[b] != 2'd0) begin
          depth_d[b] = depth_q[b] - 2'd1;
        end else begin
          depth_d[b] = 2'd0;
        end
      end
    end
  end

  // Depth registers.
  always_ff @(posedge frame_clk or negedge RESET_n) begin
    if (!RESET_n) begin
      for (int b = 0; b < N_BUTTON; b++) begin
        depth_q[b] <= 2'd0;
      end
    end else begin
      for (int b = 0; b < N_BUTTON; b++) begin
        depth_q[b] <= depth_d[b];
      end
    end
  end

  // Drive the depth output straight from the registers.
  always_comb begin
    for (int b = 0; b < N_BUTTON; b++) begin
      buttonDepth[b] = depth_q[b];
    end
  end

endmodule

// File: tb/tb_button_detect.sv
// Self-checking bench for button_detect: directed scenarios followed by
// random player motion, compared against a window-based reference model.
module tb_button_detect;
  import button_pkg::*;

  localparam int HOLD  = 8;
  localparam int DEPTH = 3;

  logic       frame_clk = 1'b0;
  logic       RESET_n;
  logic [9:0] playerX       [N_PLAYER];
  logic [9:0] playerY       [N_PLAYER];
  logic [9:0] buttonX       [N_BUTTON];
  logic [9:0] buttonY       [N_BUTTON];
  logic       buttonTrigger [N_PLAYER][N_BUTTON];
  logic [1:0] buttonDepth   [N_BUTTON];
  logic       contact       [N_PLAYER][N_BUTTON];

  int total = 0;
  int bad   = 0;

  // Reference model state.
  int edge_n;
  int last_c    [N_PLAYER][N_BUTTON];  // edge index of latest registered contact
  bit exp_c     [N_PLAYER][N_BUTTON];
  bit exp_win   [N_PLAYER][N_BUTTON];  // trigger in hold-timer mode
  bit exp_tog   [N_PLAYER][N_BUTTON];
  bit exp_t     [N_PLAYER][N_BUTTON];
  int exp_d     [N_BUTTON];

  button_detect dut (
    .frame_clk     (frame_clk),
    .RESET_n       (RESET_n),
    .playerX       (playerX),
    .playerY       (playerY),
    .buttonX       (buttonX),
    .buttonY       (buttonY),
    .buttonTrigger (buttonTrigger),
    .buttonDepth   (buttonDepth),
    .contact       (contact)
  );

  always #5 frame_clk = ~frame_clk;

  function automatic bit touches(int px, int py, int tx, int ty);
    int bx, by, feet;
    bx   = tx * 16;
    by   = ty * 16;
    feet = py + 32;
    return (feet >= by) && (feet <= by + 4) && (px < bx + 16) && (px + 16 > bx);
  endfunction

  // Trigger after edge n is high iff a contact was registered within the
  // last HOLD+1 edges before it.
  function automatic bit in_window(int last, int n);
    return (last <= n - 1) && (last >= n - 1 - HOLD);
  endfunction

  task automatic model_reset();
    edge_n = 0;
    for (int p = 0; p < N_PLAYER; p++) begin
      for (int b = 0; b < N_BUTTON; b++) begin
        last_c[p][b]  = -1000;
        exp_c[p][b]   = 1'b0;
        exp_win[p][b] = 1'b0;
        exp_tog[p][b] = 1'b0;
        exp_t[p][b]   = 1'b0;
      end
    end
    for (int b = 0; b < N_BUTTON; b++) exp_d[b] = 0;
  endtask

  task automatic check(string tag, logic [3:0] obs, logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d edge=%0d", tag, obs, exp, edge_n);
    end
  endtask

  task automatic check_all();
    for (int p = 0; p < N_PLAYER; p++) begin
      for (int b = 0; b < N_BUTTON; b++) begin
        check($sformatf("contact[%0d][%0d]", p, b), 4'(contact[p][b]), 4'(exp_c[p][b]));
        check($sformatf("trigger[%0d][%0d]", p, b), 4'(buttonTrigger[p][b]), 4'(exp_t[p][b]));
      end
    end
    for (int b = 0; b < N_BUTTON; b++) begin
      check($sformatf("depth[%0d]", b), 4'(buttonDepth[b]), 4'(exp_d[b]));
    end
  endtask

  // One frame: evaluate contact on current inputs, clock, update model, check.
  task automatic step();
    bit now_c [N_PLAYER][N_BUTTON];
    bit any_t;
    bit new_win;
    for (int p = 0; p < N_PLAYER; p++)
      for (int b = 0; b < N_BUTTON; b++)
        now_c[p][b] = touches(int'(playerX[p]), int'(playerY[p]),
                              int'(buttonX[b]), int'(buttonY[b]));
    @(posedge frame_clk);
    edge_n++;
    for (int b = 0; b < N_BUTTON; b++) begin
      any_t = 1'b0;
      for (int p = 0; p < N_PLAYER; p++) any_t |= exp_t[p][b];
      if (any_t) exp_d[b] = (exp_d[b] < DEPTH) ? exp_d[b] + 1 : DEPTH;
      else       exp_d[b] = (exp_d[b] > 0) ? exp_d[b] - 1 : 0;
    end
    for (int p = 0; p < N_PLAYER; p++) begin
      for (int b = 0; b < N_BUTTON; b++) begin
        new_win = in_window(last_c[p][b], edge_n);
        if (new_win && !exp_win[p][b]) exp_tog[p][b] = ~exp_tog[p][b];
        exp_win[p][b] = new_win;
`ifdef BUTTON_TOGGLE_EN
        exp_t[p][b] = exp_tog[p][b];
`else
        exp_t[p][b] = new_win;
`endif
        if (now_c[p][b]) last_c[p][b] = edge_n;
        exp_c[p][b] = now_c[p][b];
      end
    end
    #1;
    check_all();
  endtask

  task automatic steps(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic place(int p, int x, int y);
    playerX[p] = 10'(x);
    playerY[p] = 10'(y);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic mid_reset();
    #2;
    RESET_n = 1'b0;
    #1;
    model_reset();
    check_all();
    #1;
    RESET_n = 1'b1;
  endtask

  initial begin
    int b;
    RESET_n = 1'b0;
    for (int i = 0; i < N_BUTTON; i++) begin
      buttonX[i] = DEF_BTN_TILE_X[i];
      buttonY[i] = DEF_BTN_TILE_Y[i];
    end
    place(0, 0, 0);
    place(1, 0, 0);
    model_reset();
    #3;
    check_all();
    #9;
    RESET_n = 1'b1;

    // Land on button 0 (px 240,336).
    place(0, 240, 304);
    step();
    check("land_contact", 4'(contact[0][0]), 4'd1);
    step();
    check("land_trigger", 4'(buttonTrigger[0][0]), 4'd1);
    steps(3);
    check("land_depth", 4'(buttonDepth[0]), 4'd3);
    steps(5);

    // Step off, then ride out the hold and the depth ramp-down.
    place(0, 240, 200);
    steps(12);

    // Re-contact mid-hold, then release again.
    place(0, 240, 304);
    steps(3);
    place(0, 240, 200);
    steps(4);
    place(0, 240, 304);
    step();
    place(0, 240, 200);
    steps(12);

    // Edge cases around button 0.
    place(0, 224, 304); step();
    place(0, 225, 304); step();
    place(0, 240, 308); step();
    place(0, 240, 309); step();
    place(0, 0, 0);
    steps(12);

    // Both players on button 2 (px 320,256); player 1 leaves first.
    place(0, 320, 224);
    place(1, 322, 224);
    steps(6);
    place(1, 0, 0);
    steps(4);
    mid_reset();
    place(0, 0, 0);
    steps(3);

    // Press / release / press button 3 (px 448,192).
    place(0, 448, 160); steps(2);
    place(0, 0, 0);     steps(12);
    place(0, 448, 160); steps(2);
    place(0, 0, 0);     steps(12);

    // Random wandering around the buttons.
    for (int f = 0; f < 300; f++) begin
      for (int p = 0; p < N_PLAYER; p++) begin
        if ($urandom_range(0, 2) == 0) begin
          if ($urandom_range(0, 3) == 0) begin
            place(p, int'($urandom_range(0, 639)), int'($urandom_range(0, 479)));
          end else begin
            b = int'($urandom_range(0, N_BUTTON - 1));
            place(p, int'(DEF_BTN_TILE_X[b]) * 16 - 20 + int'($urandom_range(0, 40)),
                     int'(DEF_BTN_TILE_Y[b]) * 16 - 35 + int'($urandom_range(0, 10)));
          end
        end
      end
      step();
      if (f == 150) mid_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
